// File: rtl/hexa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : hexa_pkg                                                   |
// | Brief   : Shared types and constants for the outport arbiter:        |
// |           FSM state encoding, credit counter width, index helper.    |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package hexa_pkg;

  // Arbiter FSM: waiting for a requester, or holding a packet lock.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Width of the downstream credit counter (CREDIT_MAX up to 15).
  localparam int CREDIT_W = 4;

  // Bits needed to hold an index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/outport_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : outport_rr_pick                                            |
// | Brief   : Combinational rotating-priority picker. Returns the first  |
// |           asserted request at or after rr_ptr (wrapping), as both a  |
// |           one-hot vector and a binary index.                         |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module outport_rr_pick #(
  parameter int NUM_REQ = 6,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [IDX_W:0] w_cand;

  // Scan from the farthest offset down to offset 0 so the requester closest
  // to rr_ptr is the last one written and therefore wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req[w_cand[IDX_W-1:0]]) begin
        onehot                    = '0;
        onehot[w_cand[IDX_W-1:0]] = 1'b1;
        index                     = w_cand[IDX_W-1:0];
        any                       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/outport_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : outport_arbiter                                            |
// | Brief   : Packet-granular round-robin arbiter for one router output  |
// |           port. Lock held head..tail, credit-based flow control,     |
// |           arb_ack is the per-flit transfer strobe.                   |
// | Config  : ARB_TIMEOUT_EN - force release of an owner that stops      |
// |           requesting for TIMEOUT cycles in mid-packet.               |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module outport_arbiter
  import hexa_pkg::*;
#(
  parameter int NUM_REQ    = 6,
  parameter int CREDIT_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  tail,
  input  logic                credit_in,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                arb_ack,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit_cnt,
  output logic                credit_err
);

  localparam int            IDX_W        = idx_width(NUM_REQ);
  localparam logic [CREDIT_W-1:0] C_CREDIT_MAX = CREDIT_W'(CREDIT_MAX);
  localparam logic [IDX_W-1:0]    C_LAST_IDX   = IDX_W'(NUM_REQ - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [CREDIT_W-1:0]   r_credit_cnt;
  logic                  r_credit_err;

  logic [NUM_REQ-1:0]    w_pick_onehot;
  logic [IDX_W-1:0]      w_pick_index;
  logic                  w_pick_any;
  logic                  w_xfer;
  logic                  w_release;
  logic                  w_timeout;
  logic [IDX_W-1:0]      w_rr_nxt;

  outport_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .onehot (w_pick_onehot),
    .index  (w_pick_index),
    .any    (w_pick_any)
  );

  // Priority after a release starts just past the departing owner.
  assign w_rr_nxt = (r_owner == C_LAST_IDX) ? '0 : r_owner + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int C_STALL_W = $clog2(TIMEOUT);

  logic [C_STALL_W-1:0] r_stall;

  // The TIMEOUT-th consecutive cycle with the owner not requesting releases.
  assign w_timeout = (r_state == ST_LOCK) & ~req[r_owner] &
                     (r_stall == C_STALL_W'(TIMEOUT - 1));

  // Count owner-idle cycles; credit starvation neither counts nor clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((r_state != ST_LOCK) || w_xfer || w_timeout) begin
      r_stall <= '0;
    end else if (!req[r_owner]) begin
      r_stall <= r_stall + C_STALL_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transfer decode.
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        w_xfer    = req[r_owner] & (r_credit_cnt != '0);
        w_release = (w_xfer & tail[r_owner]) | w_timeout;
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner on lock, clear the grant and advance priority on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner  <= '0;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else if ((r_state == ST_IDLE) && w_pick_any) begin
      r_owner <= w_pick_index;
      r_gnt   <= w_pick_onehot;
    end else if (w_release) begin
      r_gnt    <= '0;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Downstream credits: a transfer spends one, credit_in returns one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit_cnt <= C_CREDIT_MAX;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_xfer, credit_in})
        2'b10: r_credit_cnt <= r_credit_cnt - CREDIT_W'(1);
        2'b01: begin
          if (r_credit_cnt == C_CREDIT_MAX) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + CREDIT_W'(1);
          end
        end
        default: r_credit_cnt <= r_credit_cnt;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign arb_ack    = w_xfer;
  assign busy       = (r_state == ST_LOCK);
  assign credit_cnt = r_credit_cnt;
  assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_outport_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_outport_arbiter                                         |
// | Brief   : Directed self-checking bench for outport_arbiter. Inputs   |
// |           change on the falling edge; outputs are sampled 1ns later. |
// | Config  : ARB_TIMEOUT_EN selects TIMEOUT=8 and the release check.    |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_outport_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] req;
  logic [5:0] tail;
  logic       credit_in;
  logic [5:0] gnt;
  logic       arb_ack;
  logic       busy;
  logic [3:0] credit_cnt;
  logic       credit_err;

  int n_cmp = 0;
  int n_err = 0;

  outport_arbiter #(
    .NUM_REQ    (6),
    .CREDIT_MAX (4),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .gnt        (gnt),
    .arb_ack    (arb_ack),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (inputs are driven here).
  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    tail      = '0;
    credit_in = 1'b0;

    // ---------------- reset state
    nedge(); nedge(); #1;
    chk("rst_gnt", {2'b0, gnt}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h0);
    chk("rst_ack", {7'b0, arb_ack}, 8'h0);
    chk("rst_cnt", {4'b0, credit_cnt}, 8'h4);
    chk("rst_err", {7'b0, credit_err}, 8'h0);
    nedge(); reset = 1'b0;

    // ---------------- 1: three-flit packet from port 2
    nedge(); req = 6'b000100; #1;
    chk("t1_idle_ack", {7'b0, arb_ack}, 8'h0);
    chk("t1_idle_busy", {7'b0, busy}, 8'h0);
    nedge(); #1;
    chk("t1_gnt", {2'b0, gnt}, 8'h04);
    chk("t1_busy", {7'b0, busy}, 8'h1);
    chk("t1_ack1", {7'b0, arb_ack}, 8'h1);
    nedge(); #1;
    chk("t1_ack2", {7'b0, arb_ack}, 8'h1);
    chk("t1_cnt3", {4'b0, credit_cnt}, 8'h3);
    nedge(); tail = 6'b000100; #1;
    chk("t1_ack3", {7'b0, arb_ack}, 8'h1);
    nedge(); req = '0; tail = '0; credit_in = 1'b1; #1;
    chk("t1_rel_gnt", {2'b0, gnt}, 8'h00);
    chk("t1_rel_busy", {7'b0, busy}, 8'h0);
    chk("t1_rel_ack", {7'b0, arb_ack}, 8'h0);
    chk("t1_cnt1", {4'b0, credit_cnt}, 8'h1);
    nedge(); #1;
    chk("t1_ret2", {4'b0, credit_cnt}, 8'h2);
    nedge(); #1;
    chk("t1_ret3", {4'b0, credit_cnt}, 8'h3);
    nedge(); credit_in = 1'b0; #1;
    chk("t1_ret4", {4'b0, credit_cnt}, 8'h4);

    // ---------------- 2: all ports, single-flit packets, rr_ptr starts at 3
    req = 6'b111111; tail = 6'b111111; #1;
    chk("t2_start_busy", {7'b0, busy}, 8'h0);
    for (int k = 0; k < 7; k++) begin
      nedge(); credit_in = 1'b1; #1;
      chk("t2_gnt", {2'b0, gnt}, 8'(6'b000001 << ((3 + k) % 6)));
      chk("t2_ack_hi", {7'b0, arb_ack}, 8'h1);
      nedge(); credit_in = 1'b0;
      if (k == 6) begin
        req = '0; tail = '0;
      end
      #1;
      chk("t2_bubble_gnt", {2'b0, gnt}, 8'h00);
      chk("t2_ack_lo", {7'b0, arb_ack}, 8'h0);
    end
    chk("t2_cnt", {4'b0, credit_cnt}, 8'h4);
    chk("t2_err", {7'b0, credit_err}, 8'h0);

    // ---------------- 3: port 2 starves on credits (rr_ptr now 4)
    nedge(); req = 6'b000100;
    nedge(); #1;
    chk("t3_gnt", {2'b0, gnt}, 8'h04);
    nedge(); nedge(); nedge();
    nedge(); #1;
    chk("t3_cnt0", {4'b0, credit_cnt}, 8'h0);
    chk("t3_ack_starved", {7'b0, arb_ack}, 8'h0);
    chk("t3_gnt_held", {2'b0, gnt}, 8'h04);
    nedge(); credit_in = 1'b1; #1;
    chk("t3_ack_same_cyc", {7'b0, arb_ack}, 8'h0);
    nedge(); credit_in = 1'b0; #1;
    chk("t3_ack_resume", {7'b0, arb_ack}, 8'h1);
    chk("t3_cnt1", {4'b0, credit_cnt}, 8'h1);
    nedge(); #1;
    chk("t3_ack_once", {7'b0, arb_ack}, 8'h0);

    // ---------------- 4: simultaneous credit/xfer, then overflow
    credit_in = 1'b1;
    nedge(); req = 6'b000001; #1;
    chk("t4_other_ignored", {2'b0, gnt}, 8'h04);
    chk("t4_no_xfer", {7'b0, arb_ack}, 8'h0);
    chk("t4_busy_kept", {7'b0, busy}, 8'h1);
    chk("t4_cnt1", {4'b0, credit_cnt}, 8'h1);
    nedge(); req = 6'b000100; tail = 6'b000100; #1;
    chk("t4_cnt2", {4'b0, credit_cnt}, 8'h2);
    chk("t4_tail_ack", {7'b0, arb_ack}, 8'h1);
    nedge(); req = '0; tail = '0; #1;
    chk("t4_cnt_unch", {4'b0, credit_cnt}, 8'h2);
    chk("t4_idle", {7'b0, busy}, 8'h0);
    nedge(); nedge(); #1;
    chk("t4_cnt_full", {4'b0, credit_cnt}, 8'h4);
    chk("t4_err_before", {7'b0, credit_err}, 8'h0);
    nedge(); credit_in = 1'b0; #1;
    chk("t4_cnt_sat", {4'b0, credit_cnt}, 8'h4);
    chk("t4_err_set", {7'b0, credit_err}, 8'h1);

    // ---------------- 6: reset in mid-packet (rr_ptr now 3)
    req = 6'b001000;
    nedge(); #1;
    chk("t6_gnt", {2'b0, gnt}, 8'h08);
    nedge(); nedge();
    nedge(); #1;
    chk("t6_cnt1", {4'b0, credit_cnt}, 8'h1);
    reset = 1'b1; #1;
    chk("t6_gnt0", {2'b0, gnt}, 8'h00);
    chk("t6_busy0", {7'b0, busy}, 8'h0);
    chk("t6_cnt4", {4'b0, credit_cnt}, 8'h4);
    chk("t6_err0", {7'b0, credit_err}, 8'h0);
    nedge(); req = '0; reset = 1'b0;

    // ---------------- 5: owner 1 stops requesting mid-packet (rr_ptr 0)
    nedge(); req = 6'b000010;
    nedge(); #1;
    chk("t5_gnt", {2'b0, gnt}, 8'h02);
    chk("t5_ack", {7'b0, arb_ack}, 8'h1);
    nedge(); req = 6'b000001;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) nedge();
      #1;
      chk("t5_stall_gnt", {2'b0, gnt}, 8'h02);
      chk("t5_stall_ack", {7'b0, arb_ack}, 8'h0);
    end
`ifdef ARB_TIMEOUT_EN
    nedge(); #1;
    chk("t5_released", {2'b0, gnt}, 8'h00);
    chk("t5_rel_busy", {7'b0, busy}, 8'h0);
    nedge(); #1;
    chk("t5_next_gnt", {2'b0, gnt}, 8'h01);
    chk("t5_next_ack", {7'b0, arb_ack}, 8'h1);
`else
    for (int i = 0; i < 110; i++) nedge();
    #1;
    chk("t5_held_gnt", {2'b0, gnt}, 8'h02);
    chk("t5_held_busy", {7'b0, busy}, 8'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
